decode_issue_queue: RTL and testbench

- Parametrised buffer between the Decode stage and the Issue stage.
- Holds up to DEPTH decoded-instruction bundles using a valid/ready handshake on both sides, so an Issue stall no longer freezes Decode immediately.
- Generalises the single branch-shadow discard: a redirect flush empties the queue, then drops the next DISCARD accepted bundles, where DISCARD is configurable.

---
 rtl/decode_issue_queue_pkg.sv | 65 ++++++
 rtl/decode_queue_ptr.sv | 80 ++++++++
 rtl/decode_issue_queue.sv | 70 +++++++
 tb/tb_decode_issue_queue.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/decode_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_queue_pkg
// Brief    : Shared types and constants for the Decode -> Issue queue.
//            Defines the decoded-bundle layout, its field offsets, the
//            bundle width and the default queue depth / discard count.
// Revision : 1.0 - initial release
// ============================================================================
package decode_issue_queue_pkg;

  // Decoded-instruction bundle; the last field sits at bit 0.
  typedef struct packed {
    logic [21:0] spare;        // reserved for future decode fields
    logic [31:0] imm;          // extended immediate
    logic        selalushift;
    logic        selimregb;
    logic [2:0]  aluop;
    logic        unsig;
    logic [1:0]  shiftop;
    logic        readmem;
    logic        writemem;
    logic        imedext;
    logic        selwsource;
    logic [4:0]  regdest;
    logic        writereg;
    logic        writeov;
    logic        selregdest;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  addra;
    logic [4:0]  addrb;
  } decode_bundle_t;

  localparam int DECODE_BUNDLE_W = $bits(decode_bundle_t);

  // Bit offset (LSB) of each field within a flattened bundle.
  localparam int OFF_ADDRB       = 0;
  localparam int OFF_ADDRA       = 5;
  localparam int OFF_FUNCT       = 10;
  localparam int OFF_OP          = 16;
  localparam int OFF_SELREGDEST  = 22;
  localparam int OFF_WRITEOV     = 23;
  localparam int OFF_WRITEREG    = 24;
  localparam int OFF_REGDEST     = 25;
  localparam int OFF_SELWSOURCE  = 30;
  localparam int OFF_IMEDEXT     = 31;
  localparam int OFF_WRITEMEM    = 32;
  localparam int OFF_READMEM     = 33;
  localparam int OFF_SHIFTOP     = 34;
  localparam int OFF_UNSIG       = 36;
  localparam int OFF_ALUOP       = 37;
  localparam int OFF_SELIMREGB   = 40;
  localparam int OFF_SELALUSHIFT = 41;
  localparam int OFF_IMM         = 42;
  localparam int OFF_SPARE       = 74;

  // Queue defaults.
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_DISCARD = 1;

  // Discard counter width; covers DISCARD values 0..15.
  localparam int DISC_CNT_W      = 4;

endpackage : decode_issue_queue_pkg
`default_nettype wire

// File: rtl/decode_queue_ptr.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue_ptr
// Brief    : Head/tail/occupancy and post-flush discard controller for the
//            decode issue queue. Produces handshake outputs and the storage
//            write strobe; holds no payload.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue_ptr
  import decode_issue_queue_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int DISCARD = DEFAULT_DISCARD,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  output logic             deq_valid,
  input  logic             deq_ready,
  input  logic             flush,
  output logic             write_en,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             discarding
);

  logic [DISC_CNT_W-1:0] disc_cnt;
  logic                  enq_fire;
  logic                  deq_fire;
  logic                  store;
  logic                  drop;

  // Handshake and fire decode; a flush cycle suppresses both sides.
  always_comb begin
    enq_ready  = (count != CNT_W'(DEPTH));
    deq_valid  = (count != '0) && !flush;
    enq_fire   = enq_valid && enq_ready && !flush;
    deq_fire   = deq_valid && deq_ready;
    store      = enq_fire && (disc_cnt == '0);
    drop       = enq_fire && (disc_cnt != '0);
    write_en   = store;
    discarding = (disc_cnt != '0);
  end

  // Pointer, occupancy and discard-counter state; flush empties and reloads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      disc_cnt <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      disc_cnt <= DISC_CNT_W'(DISCARD);
    end else begin
      if (store) begin
        tail <= tail + 1'b1;
      end
      if (deq_fire) begin
        head <= head + 1'b1;
      end
      case ({store, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        disc_cnt <= disc_cnt - 1'b1;
      end
    end
  end

endmodule : decode_queue_ptr
`default_nettype wire

// File: rtl/decode_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_queue
// Brief    : DEPTH-entry valid/ready buffer between Decode and Issue. A
//            redirect flush empties the queue and then drops the next
//            DISCARD accepted bundles (branch-shadow discard).
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int WIDTH   = DECODE_BUNDLE_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int DISCARD = DEFAULT_DISCARD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  logic [WIDTH-1:0]         enq_data,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output logic [WIDTH-1:0]         deq_data,
  input  logic                     deq_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     discarding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             write_en;

  decode_queue_ptr #(
    .DEPTH   (DEPTH),
    .DISCARD (DISCARD),
    .PTR_W   (PTR_W),
    .CNT_W   (CNT_W)
  ) u_ptr (
    .clock      (clock),
    .reset      (reset),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .deq_valid  (deq_valid),
    .deq_ready  (deq_ready),
    .flush      (flush),
    .write_en   (write_en),
    .head       (head),
    .tail       (tail),
    .count      (count),
    .discarding (discarding)
  );

  // Payload storage; deliberately not reset, validity lives in the controller.
  always_ff @(posedge clock) begin
    if (write_en) begin
      storage[tail] <= enq_data;
    end
  end

  // Zero-latency head read.
  always_comb begin
    deq_data = storage[head];
  end

endmodule : decode_issue_queue
`default_nettype wire

// File: tb/tb_decode_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue_queue
// Brief    : Scoreboard bench for decode_issue_queue (DEPTH=4, DISCARD=2).
//            A queue-based reference model predicts occupancy, handshakes,
//            the discard window and delivered data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue_queue;

  localparam int W    = 96;
  localparam int DEP  = 4;
  localparam int DISC = 2;

  logic          clock;
  logic          reset;
  logic          enq_valid;
  logic [W-1:0]  enq_data;
  logic          enq_ready;
  logic          deq_valid;
  logic [W-1:0]  deq_data;
  logic          deq_ready;
  logic          flush;
  logic [2:0]    count;
  logic          discarding;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: expected queue contents and remaining discards.
  logic [W-1:0] sb [$];
  int           mdisc = 0;

  decode_issue_queue #(
    .WIDTH   (W),
    .DEPTH   (DEP),
    .DISCARD (DISC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enq_valid  (enq_valid),
    .enq_data   (enq_data),
    .enq_ready  (enq_ready),
    .deq_valid  (deq_valid),
    .deq_data   (deq_data),
    .deq_ready  (deq_ready),
    .flush      (flush),
    .count      (count),
    .discarding (discarding)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare DUT against the model mid-cycle, then advance the model
  always @(negedge clock) begin : monitor
    bit exp_ready;
    bit exp_valid;
    if (!reset) begin
      sb.delete();
      mdisc = 0;
      chk("rst_count", W'(count), W'(0));
      chk("rst_deq_valid", W'(deq_valid), W'(0));
      chk("rst_enq_ready", W'(enq_ready), W'(1));
      chk("rst_discarding", W'(discarding), W'(0));
    end else begin
      exp_ready = (sb.size() != DEP);
      exp_valid = (sb.size() != 0) && !flush;
      chk("count", W'(count), W'(sb.size()));
      chk("enq_ready", W'(enq_ready), W'(exp_ready));
      chk("deq_valid", W'(deq_valid), W'(exp_valid));
      chk("discarding", W'(discarding), W'(mdisc != 0));
      if (exp_valid && deq_ready) begin
        chk("deq_data", deq_data, sb[0]);
      end
      if (flush) begin
        sb.delete();
        mdisc = DISC;
      end else begin
        if (exp_valid && deq_ready) begin
          void'(sb.pop_front());
        end
        if (enq_valid && exp_ready) begin
          if (mdisc == 0) sb.push_back(enq_data);
          else            mdisc--;
        end
      end
    end
  end

  // One cycle of stimulus: inputs change just after the rising edge.
  task automatic step(input logic ev, input logic [W-1:0] d,
                      input logic dr, input logic fl);
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    flush     = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Fill to full, then offer a fifth bundle that must be refused.
    for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Drain four, then one extra idle-ready cycle on the empty queue.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Steady stream with pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)  step(1'b0, '0, 1'b1, 1'b0);

    // Flush with three queued, colliding with an enqueue and a dequeue.
    for (int i = 0; i < 3; i++) step(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
    step(1'b1, W'(32'hD), 1'b1, 1'b1);
    step(1'b1, W'(32'hA), 1'b0, 1'b0);
    step(1'b1, W'(32'hB), 1'b0, 1'b0);
    step(1'b1, W'(32'hC), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back flushes reload rather than accumulate.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, W'(32'hE0), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, W'(32'hE1 + i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with two entries queued.
    for (int i = 0; i < 2; i++) step(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           {$urandom, $urandom, $urandom},
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_decode_issue_queue
`default_nettype wire
